// File: rtl/nios_system_key_debounce.sv
// nios_system_key_debounce: per-key synchronise-and-debounce of active-low buttons, with press/release strobes.
module nios_system_key_debounce #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_db,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q, db_q, db_d, press_q, press_d, release_q, release_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // A single sample matching the accepted level discards any partial count.
    always_comb begin
        db_d      = db_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i]      = sync2_q[i];
                    press_d[i]   = ~sync2_q[i];
                    release_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            db_q      <= '1;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= key_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign key_db        = db_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
endmodule

// File: tb/tb_nios_system_key_debounce.sv
// tb_nios_system_key_debounce: per-cycle model comparison plus directed literal checks for the key debouncer.
module tb_nios_system_key_debounce;
    localparam int W = 4;
    localparam int S = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] key_raw;
    logic [W-1:0] key_db, press_pulse, release_pulse;
    int           total = 0;
    int           bad   = 0;

    nios_system_key_debounce #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .key_raw(key_raw),
        .key_db(key_db), .press_pulse(press_pulse), .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: a level is accepted once S consecutive raw samples, seen two edges late, differ from it.
    logic [W-1:0] m_db, m_press, m_rel, seen;
    logic [W-1:0] hist[$];
    int           run[W];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_db = '1; m_press = '0; m_rel = '0;
            hist = '{4'hF, 4'hF};
            for (int i = 0; i < W; i++) run[i] = 0;
        end else begin
            seen = hist[0];
            hist.push_back(key_raw);
            void'(hist.pop_front());
            m_press = '0; m_rel = '0;
            for (int i = 0; i < W; i++) begin
                if (seen[i] == m_db[i]) run[i] = 0;
                else begin
                    run[i]++;
                    if (run[i] == S) begin
                        m_db[i] = seen[i];
                        m_press[i] = ~seen[i];
                        m_rel[i] = seen[i];
                        run[i] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model key_db", key_db, m_db);
        chk("model press", press_pulse, m_press);
        chk("model release", release_pulse, m_rel);
    end

    initial begin
        reset = 1'b1;
        key_raw = 4'h0;
        #1;
        chk("reset key_db", key_db, 4'hF);
        chk("reset press", press_pulse, 4'h0);
        chk("reset release", release_pulse, 4'h0);
        key_raw = 4'hF;
        tick(2);
        reset = 1'b0;
        tick(2);
        // clean press and release on key 0
        key_raw = 4'hE;
        tick(9);
        chk("press0 early", key_db, 4'hF);
        tick(1);
        chk("press0 db", key_db, 4'hE);
        chk("press0 pulse", press_pulse, 4'h1);
        tick(1);
        chk("press0 pulse end", press_pulse, 4'h0);
        key_raw = 4'hF;
        tick(9);
        chk("rel0 early", key_db, 4'hE);
        tick(1);
        chk("rel0 db", key_db, 4'hF);
        chk("rel0 pulse", release_pulse, 4'h1);
        tick(3);
        // bounce on key 1
        for (int k = 0; k < 7; k++) begin
            key_raw = 4'hD; tick(3);
            key_raw = 4'hF; tick(3);
        end
        key_raw = 4'hD;
        tick(9);
        chk("bounce early", key_db, 4'hF);
        tick(1);
        chk("bounce db", key_db, 4'hD);
        chk("bounce pulse", press_pulse, 4'h2);
        key_raw = 4'hF;
        tick(12);
        chk("bounce released", key_db, 4'hF);
        // 7-cycle glitch on key 2 is ignored, 8-cycle one is accepted
        key_raw = 4'hB; tick(7);
        key_raw = 4'hF; tick(12);
        chk("glitch7 db", key_db, 4'hF);
        key_raw = 4'hB; tick(8);
        key_raw = 4'hF; tick(2);
        chk("glitch8 db", key_db, 4'hB);
        chk("glitch8 press", press_pulse, 4'h4);
        tick(7);
        chk("glitch8 hold", key_db, 4'hB);
        tick(1);
        chk("glitch8 rel db", key_db, 4'hF);
        chk("glitch8 rel", release_pulse, 4'h4);
        tick(3);
        // simultaneous keys 0 and 3
        key_raw = 4'h6;
        tick(9);
        chk("simul early", key_db, 4'hF);
        tick(1);
        chk("simul db", key_db, 4'h6);
        chk("simul press", press_pulse, 4'h9);
        key_raw = 4'hF;
        tick(10);
        chk("simul rel db", key_db, 4'hF);
        chk("simul rel", release_pulse, 4'h9);
        tick(3);
        // reset mid-count on key 1
        key_raw = 4'hD;
        tick(5);
        reset = 1'b1;
        #1;
        chk("midreset db", key_db, 4'hF);
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("postreset press", press_pulse, 4'h0);
        tick(8);
        chk("midreset early", key_db, 4'hF);
        tick(1);
        chk("midreset db fall", key_db, 4'hD);
        chk("midreset press", press_pulse, 4'h2);
        key_raw = 4'hF;
        tick(12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
